// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// Module  : alu_muldiv_iter
// Brief   : Iterative RISC-V M-extension multiply/divide, one bit per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [Width-1:0] A1,
  input  logic [Width-1:0] A2,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] Y,
  output logic             zero
);

  localparam int CntW = $clog2(Width + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2:0]         op_q;
  logic               spec_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic [Width-1:0]   operand;
  logic [2*Width-1:0] acc;
  logic [CntW-1:0]    cnt;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [Width-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf, special;
  logic [Width-1:0]   preset;
  logic [Width:0]     mul_sum;
  logic [Width:0]     div_shift, div_diff;
  logic [2*Width-1:0] mul_next, div_next;
  logic [2*Width-1:0] prod;
  logic [Width-1:0]   quo, rem, result;

  // Accept-time decode: signedness, magnitudes and the two divide special cases
  always_comb begin
    a_signed = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
               (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b000) || (op == 3'b001) ||
               (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed & A1[Width-1];
    b_neg    = b_signed & A2[Width-1];
    a_mag    = a_neg ? (~A1 + 1'b1) : A1;
    b_mag    = b_neg ? (~A2 + 1'b1) : A2;
    div_zero = op[2] && (A2 == '0);
    div_ovf  = op[2] && !op[0] && (A1 == {1'b1, {(Width-1){1'b0}}}) && (A2 == '1);
    special  = div_zero || div_ovf;
    preset   = '0;
    if (div_zero) begin
      preset = op[1] ? A1 : '1;
    end else if (div_ovf) begin
      preset = op[1] ? '0 : A1;
    end
  end

  // Multiply keeps {carry+high, multiplier} and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left with a Width+1 trial subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*Width-1:Width]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next  = {mul_sum, acc[Width-1:1]};
    div_shift = acc[2*Width-1:Width-1];
    div_diff  = div_shift - {1'b0, operand};
    div_next  = {(div_diff[Width] ? div_shift[Width-1:0] : div_diff[Width-1:0]),
                 acc[Width-2:0], ~div_diff[Width]};
  end

  always_comb begin
    prod   = neg_q ? (~acc + 1'b1) : acc;
    quo    = neg_q ? (~acc[Width-1:0] + 1'b1) : acc[Width-1:0];
    rem    = rem_neg_q ? (~acc[2*Width-1:Width] + 1'b1) : acc[2*Width-1:Width];
    result = '0;
    if (spec_q) begin
      result = acc[Width-1:0];
    end else begin
      case (op_q)
        3'b000:                 result = prod[Width-1:0];
        3'b001, 3'b010, 3'b011: result = prod[2*Width-1:Width];
        3'b100, 3'b101:         result = quo;
        default:                result = rem;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? FIX : CALC;
      CALC:    if (cnt == CntW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      spec_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Y         <= '0;
      zero      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            spec_q    <= special;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            operand   <= op[2] ? b_mag : a_mag;
            acc       <= special ? {{Width{1'b0}}, preset}
                       : (op[2] ? {{Width{1'b0}}, a_mag} : {{Width{1'b0}}, b_mag});
            cnt       <= CntW'(Width);
            busy      <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          acc <= op_q[2] ? div_next : mul_next;
        end
        FIX: begin
          Y    <= result;
          zero <= (result == '0);
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
// ============================================================================
// Module  : tb_alu_muldiv_iter
// Brief   : Scoreboard bench for alu_muldiv_iter with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_iter;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] A1 = '0;
  logic [31:0] A2 = '0;
  logic        busy, done, zero;
  logic [31:0] Y;

  alu_muldiv_iter #(.Width(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A1(A1), .A2(A2),
    .busy(busy), .done(done), .Y(Y), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] y;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, ".Y"}, Y, e.y);
        chk({e.name, ".zero"}, {31'b0, zero}, {31'b0, (e.y == 32'h0)});
        chk({e.name, ".latency"}, cyc - e.acc_cyc, e.lat);
        chk({e.name, ".busy_in_done"}, {31'b0, busy}, 32'h0);
      end
    end
  end

  // Called at a negedge; the following posedge is the accept edge.
  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] y, input int lat);
    exp_t e;
    start = 1'b1; op = o; A1 = a; A2 = b;
    e.name = name; e.y = y; e.acc_cyc = cyc + 1; e.lat = lat;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0; op = '0; A1 = '0; A2 = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.busy", {31'b0, busy}, 32'h0);
    chk("reset.done", {31'b0, done}, 32'h0);
    chk("reset.Y",    Y, 32'h0);
    chk("reset.zero", {31'b0, zero}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    issue("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    chk("mul.busy_after_accept", {31'b0, busy}, 32'h1);
    drain();
    issue("mulh_minmin",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33); drain();
    issue("mulhu_ones",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33); drain();
    issue("mulhsu_ones",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33); drain();
    issue("mulhu_small",  MULHU,  32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 33); drain();
    issue("divu_100_7",   DIVU,   32'd100, 32'd7, 32'd14, 33); drain();
    issue("remu_100_7",   REMU,   32'd100, 32'd7, 32'd2,  33); drain();
    issue("div_m7_2",     DIV,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33); drain();
    issue("rem_m7_2",     REM,    32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33); drain();
    issue("divu_max_1",   DIVU,   32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33); drain();
    issue("remu_14_7",    REMU,   32'd14, 32'd7, 32'd0, 33); drain();

    issue("div_by_zero",  DIV,    32'd123, 32'd0, 32'hFFFF_FFFF, 1); drain();
    issue("rem_5_by_0",   REM,    32'd5, 32'd0, 32'd5, 1); drain();
    issue("divu_by_zero", DIVU,   32'd9, 32'd0, 32'hFFFF_FFFF, 1); drain();
    issue("remu_9_by_0",  REMU,   32'd9, 32'd0, 32'd9, 1); drain();
    issue("div_ovf",      DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); drain();
    issue("rem_ovf",      REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1); drain();

    // A start pulse mid-flight must not disturb the running divide
    issue("div_1000_m10", DIV, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 33);
    repeat (9) @(negedge clk);
    start = 1'b1; op = DIVU; A1 = 32'd5; A2 = 32'd5;
    @(negedge clk);
    start = 1'b0; op = '0; A1 = '0; A2 = '0;
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    // Back-to-back: issue in the done cycle of the divide
    issue("b2b_mul_6_7", MUL, 32'd6, 32'd7, 32'd42, 33);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    issue("b2b_rem_m9_4", REM, 32'hFFFF_FFF7, 32'd4, 32'hFFFF_FFFF, 33);
    drain();

    // Reset mid-operation discards the partial result
    issue("mul_aborted", MUL, 32'h0000_1234, 32'h0000_5678, 32'h0, 33);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst.busy", {31'b0, busy}, 32'h0);
    chk("midrst.done", {31'b0, done}, 32'h0);
    chk("midrst.Y",    Y, 32'h0);
    chk("midrst.zero", {31'b0, zero}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue("mul_3_4", MUL, 32'd3, 32'd4, 32'd12, 33);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
